// File: rtl/alu_sequencer.sv
// Two-requester round-robin front end for a multi-cycle ALU: latch, issue, wait, respond.
// Optional ALU_SEQ_CHECK_EN rejects requests whose operand-valid pattern does not suit the command.
module alu_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_mode,
    input  logic                 req0_cin,
    input  logic [CMD_WIDTH-1:0] req0_cmd,
    input  logic [1:0]           req0_inp_valid,
    input  logic [WIDTH-1:0]     req0_opa,
    input  logic [WIDTH-1:0]     req0_opb,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_mode,
    input  logic                 req1_cin,
    input  logic [CMD_WIDTH-1:0] req1_cmd,
    input  logic [1:0]           req1_inp_valid,
    input  logic [WIDTH-1:0]     req1_opa,
    input  logic [WIDTH-1:0]     req1_opb,
    output logic                 alu_ce,
    output logic                 alu_mode,
    output logic                 alu_cin,
    output logic [CMD_WIDTH-1:0] alu_cmd,
    output logic [1:0]           alu_inp_valid,
    output logic [WIDTH-1:0]     alu_opa,
    output logic [WIDTH-1:0]     alu_opb,
    input  logic [WIDTH:0]       alu_res,
    input  logic                 alu_err,
    input  logic                 alu_oflow,
    input  logic                 alu_cout,
    input  logic                 alu_g,
    input  logic                 alu_l,
    input  logic                 alu_e,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [WIDTH:0]       rsp_res,
    output logic                 rsp_err,
    output logic                 rsp_oflow,
    output logic                 rsp_cout,
    output logic                 rsp_g,
    output logic                 rsp_l,
    output logic                 rsp_e,
    output logic                 busy
);
    // state | meaning
    // IDLE  | ready offered to the arbitration winner
    // ISSUE | ALU enabled, latency counter loaded
    // WAIT  | ALU enabled, counting down to result capture
    // RESP  | rsp_valid for one cycle
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic                 id_q, mode_q, cin_q, last_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [1:0]           iv_q, cnt_q;
    logic [WIDTH-1:0]     opa_q, opb_q;
    logic                 grant_id, accept, skip, is_mul;

    // Ties go to the requester that was not granted last.
    assign grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid) && rst;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign is_mul = mode_q && ((cmd_q == CMD_WIDTH'(9)) || (cmd_q == CMD_WIDTH'(10)));

`ifdef ALU_SEQ_CHECK_EN
    logic illegal_q;

    function automatic logic iv_legal(input logic mode, input logic [CMD_WIDTH-1:0] cmd,
                                      input logic [1:0] iv);
        logic [1:0] need;
        logic       known;
        need  = 2'b11;
        known = 1'b1;
        if (mode) begin
            case (int'(cmd))
                0, 1, 2, 3, 8, 9, 10: need = 2'b11;
                4, 5:                 need = 2'b01;
                6, 7:                 need = 2'b10;
                default:              known = 1'b0;
            endcase
        end else begin
            case (int'(cmd))
                0, 1, 2, 3, 4, 5, 12, 13: need = 2'b11;
                6, 8, 9:                  need = 2'b01;
                7, 10, 11:                need = 2'b10;
                default:                  known = 1'b0;
            endcase
        end
        return known && (iv == need);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            illegal_q <= 1'b0;
        else if (accept)
            illegal_q <= grant_id ? !iv_legal(req1_mode, req1_cmd, req1_inp_valid)
                                  : !iv_legal(req0_mode, req0_cmd, req0_inp_valid);
    end

    assign skip = illegal_q;
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = skip ? RESP : WAIT;
            WAIT:    if (cnt_q == 2'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            mode_q    <= 1'b0;
            cin_q     <= 1'b0;
            cmd_q     <= '0;
            iv_q      <= 2'b00;
            opa_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= 2'd0;
            rsp_id    <= 1'b0;
            rsp_res   <= '0;
            rsp_err   <= 1'b0;
            rsp_oflow <= 1'b0;
            rsp_cout  <= 1'b0;
            rsp_g     <= 1'b0;
            rsp_l     <= 1'b0;
            rsp_e     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= grant_id;
                id_q   <= grant_id;
                mode_q <= grant_id ? req1_mode      : req0_mode;
                cin_q  <= grant_id ? req1_cin       : req0_cin;
                cmd_q  <= grant_id ? req1_cmd       : req0_cmd;
                iv_q   <= grant_id ? req1_inp_valid : req0_inp_valid;
                opa_q  <= grant_id ? req1_opa       : req0_opa;
                opb_q  <= grant_id ? req1_opb       : req0_opb;
            end
            if (state_q == ISSUE)
                cnt_q <= is_mul ? 2'd3 : 2'd1;
            else if (state_q == WAIT)
                cnt_q <= cnt_q - 2'd1;
            if (state_q == WAIT && cnt_q == 2'd1) begin
                rsp_id    <= id_q;
                rsp_res   <= alu_res;
                rsp_err   <= alu_err;
                rsp_oflow <= alu_oflow;
                rsp_cout  <= alu_cout;
                rsp_g     <= alu_g;
                rsp_l     <= alu_l;
                rsp_e     <= alu_e;
            end
`ifdef ALU_SEQ_CHECK_EN
            if (state_q == ISSUE && skip) begin
                rsp_id    <= id_q;
                rsp_res   <= '0;
                rsp_err   <= 1'b1;
                rsp_oflow <= 1'b0;
                rsp_cout  <= 1'b0;
                rsp_g     <= 1'b0;
                rsp_l     <= 1'b0;
                rsp_e     <= 1'b0;
            end
`endif
        end
    end

    assign busy          = (state_q != IDLE);
    assign alu_ce        = ((state_q == ISSUE) || (state_q == WAIT)) && !skip;
    assign alu_inp_valid = alu_ce ? iv_q : 2'b00;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;
    assign alu_cmd       = cmd_q;
    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign rsp_valid     = (state_q == RESP);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a tiny behavioural ALU; build with or without ALU_SEQ_CHECK_EN.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r0_valid = 0, r0_mode = 0, r0_cin = 0, r1_valid = 0, r1_mode = 0, r1_cin = 0;
    logic [3:0] r0_cmd = 0, r1_cmd = 0;
    logic [1:0] r0_iv = 0, r1_iv = 0;
    logic [7:0] r0_opa = 0, r0_opb = 0, r1_opa = 0, r1_opb = 0;
    logic       req0_ready, req1_ready;
    logic       alu_ce, alu_mode, alu_cin;
    logic [3:0] alu_cmd;
    logic [1:0] alu_inp_valid;
    logic [7:0] alu_opa, alu_opb;
    logic [8:0] alu_res;
    logic       alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
    logic       rsp_valid, rsp_id, busy;
    logic [8:0] rsp_res;
    logic       rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e;

    int n_cmp = 0, n_err = 0;
    int edges, ce_cnt, busy_low;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(8), .CMD_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0_valid), .req0_ready(req0_ready), .req0_mode(r0_mode), .req0_cin(r0_cin),
        .req0_cmd(r0_cmd), .req0_inp_valid(r0_iv), .req0_opa(r0_opa), .req0_opb(r0_opb),
        .req1_valid(r1_valid), .req1_ready(req1_ready), .req1_mode(r1_mode), .req1_cin(r1_cin),
        .req1_cmd(r1_cmd), .req1_inp_valid(r1_iv), .req1_opa(r1_opa), .req1_opb(r1_opb),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_cmd(alu_cmd),
        .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow), .alu_cout(alu_cout),
        .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .rsp_oflow(rsp_oflow), .rsp_cout(rsp_cout), .rsp_g(rsp_g), .rsp_l(rsp_l), .rsp_e(rsp_e),
        .busy(busy)
    );

    // Behavioural ALU: mode1 cmd9 multiply, other mode1 add with carry, mode0 xor.
    always_comb begin
        alu_res = 9'd0;
        if (alu_mode && alu_cmd == 4'd9)
            alu_res = 9'(alu_opa * alu_opb);
        else if (alu_mode)
            alu_res = {1'b0, alu_opa} + {1'b0, alu_opb} + {8'd0, alu_cin};
        else
            alu_res = {1'b0, alu_opa ^ alu_opb};
        alu_err   = 1'b0;
        alu_oflow = 1'b0;
        alu_cout  = alu_res[8];
        alu_g     = alu_opa > alu_opb;
        alu_l     = alu_opa < alu_opb;
        alu_e     = alu_opa == alu_opb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic m, input logic [3:0] c,
                           input logic [7:0] a, input logic [7:0] b, input logic [1:0] iv);
        if (id) begin
            r1_mode = m; r1_cmd = c; r1_opa = a; r1_opb = b; r1_iv = iv; r1_cin = 0; r1_valid = 1;
        end else begin
            r0_mode = m; r0_cmd = c; r0_opa = a; r0_opb = b; r0_iv = iv; r0_cin = 0; r0_valid = 1;
        end
    endtask

    task automatic wait_ready(input logic id);
        int n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(id ? "ready1" : "ready0", id ? req1_ready : req0_ready, 1);
    endtask

    // Called at a negedge with ready high; counts edges from the accept edge to rsp_valid.
    task automatic wait_rsp(input int drop_id);
        @(posedge clk);
        edges = 1; ce_cnt = 0; busy_low = 0;
        @(negedge clk);
        if (drop_id == 0 || drop_id == 2) r0_valid = 0;
        if (drop_id == 1 || drop_id == 2) r1_valid = 0;
        while (!rsp_valid && edges < 30) begin
            ce_cnt += int'(alu_ce);
            if (!busy) busy_low++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        if (!busy) busy_low++;
    endtask

    initial begin
        int cnt;
        r0_valid = 1;
        #23;
        check("rst_ready0", req0_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp", {rsp_valid, rsp_res, rsp_err, rsp_g}, 0);
        check("rst_alu", {alu_ce, alu_inp_valid, alu_opa, alu_opb}, 0);
        r0_valid = 0;
        @(negedge clk); rst = 1;

        // Single add: latency 3, two enable cycles
        @(negedge clk);
        set_req(0, 1, 4'd0, 8'h05, 8'h03, 2'b11);
        wait_ready(0);
        check("add_ready1_low", req1_ready, 0);
        wait_rsp(0);
        check("add_lat", edges, 3);
        check("add_ce", ce_cnt, 2);
        check("add_res", rsp_res, 9'h008);
        check("add_id", rsp_id, 0);
        check("add_g", {rsp_g, rsp_l, rsp_e}, 3'b100);
        @(negedge clk);
        check("idle_hold", {rsp_valid, busy, alu_ce, alu_inp_valid}, 0);
        check("idle_res_hold", rsp_res, 9'h008);
        check("idle_opa_hold", alu_opa, 8'h05);

        // Multiply on req1: latency 5, busy throughout
        set_req(1, 1, 4'd9, 8'd3, 8'd4, 2'b11);
        wait_ready(1);
        wait_rsp(1);
        check("mul_lat", edges, 5);
        check("mul_ce", ce_cnt, 4);
        check("mul_busy", busy_low, 0);
        check("mul_res", rsp_res, 9'd12);
        check("mul_id", rsp_id, 1);

        // Simultaneous requests: req0 first (req1 granted last), then held req1
        set_req(0, 1, 4'd0, 8'd10, 8'd20, 2'b11);
        set_req(1, 1, 4'd0, 8'd7, 8'd1, 2'b11);
        wait_ready(0);
        check("arb_r1_low", req1_ready, 0);
        wait_rsp(0);
        check("arb_id0", rsp_id, 0);
        check("arb_res0", rsp_res, 9'd30);
        wait_ready(1);
        wait_rsp(1);
        check("arb_id1", rsp_id, 1);
        check("arb_res1", rsp_res, 9'd8);
        set_req(0, 1, 4'd0, 8'd1, 8'd1, 2'b11);
        set_req(1, 1, 4'd0, 8'd2, 8'd2, 2'b11);
        wait_ready(0);
        check("arb2_r1_low", req1_ready, 0);
        wait_rsp(2);
        set_req(0, 1, 4'd0, 8'd1, 8'd1, 2'b11);
        set_req(1, 1, 4'd0, 8'd2, 8'd2, 2'b11);
        wait_ready(1);
        check("arb3_r0_low", req0_ready, 0);
        wait_rsp(2);
        check("arb3_id", rsp_id, 1);
        check("arb3_res", rsp_res, 9'd4);

        // req0 raised and withdrawn while busy must vanish
        @(negedge clk);
        set_req(1, 1, 4'd0, 8'd9, 8'd9, 2'b11);
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        r1_valid = 0;
        set_req(0, 1, 4'd0, 8'd40, 8'd2, 2'b11);
        @(negedge clk);
        r0_valid = 0;
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin @(negedge clk); cnt++; end
        check("drop_id", rsp_id, 1);
        check("drop_res", rsp_res, 9'd18);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cnt += int'(busy) + int'(rsp_valid);
        end
        check("drop_idle", cnt, 0);

        // mode0 cmd6 with both operands flagged valid
        set_req(0, 0, 4'd6, 8'd7, 8'd2, 2'b11);
        wait_ready(0);
        wait_rsp(0);
`ifdef ALU_SEQ_CHECK_EN
        check("chk_lat", edges, 2);
        check("chk_ce", ce_cnt, 0);
        check("chk_err", rsp_err, 1);
        check("chk_res", {rsp_res, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e}, 0);
`else
        check("chk_lat", edges, 3);
        check("chk_ce", ce_cnt, 2);
        check("chk_err", rsp_err, 0);
        check("chk_res", rsp_res, 9'd5);
`endif

        // Reset during WAIT of a latency-3 op
        @(negedge clk);
        set_req(0, 1, 4'd10, 8'd3, 8'd2, 2'b11);
        wait_ready(0);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 0;
        #1;
        check("arst_busy_ce", {busy, alu_ce, alu_inp_valid, rsp_valid}, 0);
        check("arst_alu", {alu_opa, alu_opb, alu_cmd, alu_mode}, 0);
        check("arst_rsp", {rsp_res, rsp_err, rsp_g, rsp_l, rsp_e, rsp_id}, 0);
        @(negedge clk);
        rst = 1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cnt += int'(rsp_valid);
        end
        check("arst_no_rsp", cnt, 0);
        set_req(0, 1, 4'd0, 8'd1, 8'd2, 2'b11);
        set_req(1, 1, 4'd0, 8'd3, 8'd4, 2'b11);
        wait_ready(0);
        check("arst_r1_low", req1_ready, 0);
        wait_rsp(2);
        check("arst_id", rsp_id, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (matches ALU `WIDTH`).
REQ-002 SHALL have parameter CMD_WIDTH, default 4, command width (matches ALU `CMD_WIDTH`).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_valid  input  1  request from requester N (N=0,1).
REQ-006 SHALL have ports reqN_ready  output  1  request N accepted this cycle.
REQ-007 SHALL have ports reqN_mode / reqN_cin  input  1 each; reqN_cmd  input  CMD_WIDTH; reqN_inp_valid  input  2; reqN_opa, reqN_opb  input  WIDTH.
REQ-008 SHALL have ports alu_ce, alu_mode, alu_cin  output  1; alu_cmd  output  CMD_WIDTH; alu_inp_valid  output  2; alu_opa, alu_opb  output  WIDTH.
REQ-009 SHALL have ports alu_res  input  WIDTH+1; alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  input  1.
REQ-010 SHALL have ports rsp_valid  output  1; rsp_id  output  1 (granted requester); rsp_res  output  WIDTH+1; rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e  output  1.
REQ-011 SHALL have port busy  output  1  high in any state but IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-013 IDLE: reqN_ready SHALL be high combinationally for the granted requester only; valid&&ready = accept; all request fields latched on accept; next state ISSUE.
REQ-014 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last; last-grant pointer updates on accept only.
REQ-015 Requesters SHALL hold fields stable while valid and not ready; no ready asserted outside IDLE.
REQ-016 ISSUE (1 cycle) and WAIT: alu_ce=1, ALU inputs driven from latched fields, held stable.
REQ-017 Latency LAT SHALL be 3 for mode=1 with cmd 9 or 10 (multiply), else 1; WAIT lasts LAT cycles, counter loaded in ISSUE.
REQ-018 On last WAIT cycle SHALL register all alu_* result inputs into rsp_*; next state RESP.
REQ-019 RESP (1 cycle): rsp_valid=1, rsp_id=granted index; no backpressure; rsp_* hold until next capture.
REQ-020 Outside ISSUE/WAIT: alu_ce=0, alu_inp_valid=2'b00, other alu_* hold last values.
REQ-021 Accept-to-rsp_valid SHALL be 2+LAT cycles; back-to-back accepts 3+LAT cycles apart.
REQ-022 Request valid deasserted before accept SHALL be dropped without effect.

Reset
REQ-023 rst low SHALL asynchronously force IDLE, pointer favouring req0, all outputs 0 (rsp_*, alu_*, ready, busy).
REQ-024 Reset mid-operation SHALL abort the operation; no rsp_valid for it after release.

Configuration
REQ-025 Macro ALU_SEQ_CHECK_EN SHALL enable pre-issue INP_VALID legality check.
REQ-026 Legal with macro: mode=1 cmd 0-3,8,9,10 need 11; 4,5 need 01; 6,7 need 10. Mode=0 cmd 0-5,12,13 need 11; 6,8,9 need 01; 7,10,11 need 10. Other cmd illegal.
REQ-027 With macro, illegal request: accepted, ISSUE/WAIT skipped (alu_ce stays 0), RESP next cycle with rsp_err=1, other rsp_* flags 0, rsp_res 0.
REQ-028 Without macro, every request SHALL be issued unchanged; no check logic present.

Verification
REQ-029 req0 mode=1 cmd=0 opa=8'h05 opb=8'h03 inp_valid=11 -> alu_ce high 2 cycles, rsp_valid 3 cycles after accept, rsp_res=9'h008, rsp_id=0.
REQ-030 req0,req1 valid same cycle, both held -> req0 granted first, req1 next; rsp_id 0 then 1; then req1 first on repeat.
REQ-031 mode=1 cmd=9 opa=3 opb=4 -> WAIT 3 cycles, rsp_valid 5 cycles after accept, busy high throughout.
REQ-032 ALU_SEQ_CHECK_EN, mode=0 cmd=6 inp_valid=11 -> alu_ce never high, rsp_valid 2 cycles after accept, rsp_err=1; without macro issued normally.
REQ-033 rst low during WAIT -> all outputs 0 immediately, no rsp_valid after release, next simultaneous request grants req0.
